// File: rtl/RAM_shared_pkg.sv
// rtl/RAM_shared_pkg.sv - RAM geometry shared by the RAM and its SPI front end
package RAM_shared_pkg;
    localparam int ADDR_SIZE = 8;
endpackage

// File: rtl/spi_shared_pkg.sv
// rtl/spi_shared_pkg.sv - SPI slave FSM states and frame command encodings
package spi_shared_pkg;
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    // Frame bits [9:8]; decoded by the RAM, not by the SPI slave.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
endpackage

// File: rtl/spi_piso8.sv
// rtl/spi_piso8.sv - 8-bit load/shift-out register driving MISO, MSB first
module spi_piso8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       sout_o,
    output logic       done_o
);
    logic [6:0] shreg_q;
    logic [2:0] cnt_q;
    logic       busy_q;
    logic       sout_q;

    // Bit 7 goes out on the load edge itself; seven shifts follow, then an idle 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            sout_q  <= 1'b0;
        end else if (clr_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            sout_q  <= 1'b0;
        end else if (load_i) begin
            shreg_q <= data_i[6:0];
            cnt_q   <= 3'd7;
            busy_q  <= 1'b1;
            sout_q  <= data_i[7];
        end else if (busy_q) begin
            if (cnt_q != 3'd0) begin
                sout_q  <= shreg_q[6];
                shreg_q <= {shreg_q[5:0], 1'b0};
                cnt_q   <= cnt_q - 3'd1;
            end else begin
                sout_q <= 1'b0;
                busy_q <= 1'b0;
            end
        end
    end

    assign sout_o = sout_q;
    assign done_o = ~busy_q;
endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI slave: MOSI frame deserializer and MISO read-byte serializer
module spi_slave_ctrl
    import spi_shared_pkg::*;
#(
    parameter int ADDR_SIZE = RAM_shared_pkg::ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);
    localparam int         FW       = ADDR_SIZE + 2;
    localparam logic [3:0] LAST_BIT = 4'(ADDR_SIZE);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [FW-1:0]   sipo_q, sipo_d;
    logic [FW-1:0]   rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rd_addr_seen_q, rd_addr_seen_d;
    logic            done_q, done_d;
    logic            wait_tx_q, wait_tx_d;
    logic            piso_load, piso_clr, piso_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sipo_q         <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            done_q         <= 1'b0;
            wait_tx_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sipo_q         <= sipo_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            done_q         <= done_d;
            wait_tx_q      <= wait_tx_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sipo_d         = sipo_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        done_d         = done_q;
        wait_tx_d      = wait_tx_q;
        piso_load      = 1'b0;
        piso_clr       = 1'b0;
        if (SS_n) begin
            state_d   = IDLE;
            cnt_d     = '0;
            done_d    = 1'b0;
            wait_tx_d = 1'b0;
            piso_clr  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = CHK_CMD;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
                CHK_CMD: begin
                    sipo_d = {MOSI, {(FW-1){1'b0}}};
                    if (!MOSI)
                        state_d = WRITE;
                    else if (rd_addr_seen_q)
                        state_d = READ_DATA;
                    else
                        state_d = READ_ADD;
                end
                default: begin
                    // Once the frame is complete, MOSI is ignored until deselect.
                    if (!done_q) begin
                        sipo_d[LAST_BIT - cnt_q] = MOSI;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == LAST_BIT) begin
                            rx_data_d  = sipo_d;
                            rx_valid_d = 1'b1;
                            done_d     = 1'b1;
                            if (state_q == READ_ADD)
                                rd_addr_seen_d = 1'b1;
                            if (state_q == READ_DATA) begin
                                rd_addr_seen_d = 1'b0;
                                wait_tx_d      = 1'b1;
                            end
                        end
                    end else if (wait_tx_q && tx_valid && piso_done) begin
                        piso_load = 1'b1;
                        wait_tx_d = 1'b0;
                    end
                end
            endcase
        end
    end

    spi_piso8 u_piso (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (piso_clr),
        .load_i (piso_load),
        .data_i (tx_data[7:0]),
        .sout_o (MISO),
        .done_o (piso_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - self-checking bench for spi_slave_ctrl
module tb_spi_slave_ctrl;
    import spi_shared_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_checks = 0;
    int n_fail   = 0;
    bit rd_model = 1'b0;

    spi_slave_ctrl #(.ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rules: a leading 0 leaves the flag alone, a leading 1 toggles it
    // (address sets, data clears); only a data read returns a byte on MISO.
    function automatic bit model_rd_next(input logic [9:0] f, input bit rd);
        if (!f[9]) return rd;
        return !rd;
    endfunction

    function automatic bit model_reads_back(input logic [9:0] f, input bit rd);
        return f[9] && rd;
    endfunction

    task automatic send_frame(input logic [9:0] f, output int nvalid, output int vpos,
                              output logic [9:0] cap, output bit miso_hi);
        nvalid = 0; vpos = -1; cap = '0; miso_hi = 1'b0;
        @(negedge clk); SS_n = 1'b0; MOSI = 1'($urandom);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_valid) nvalid++;
            if (MISO) miso_hi = 1'b1;
            MOSI = f[9-i];
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rx_valid) begin
                nvalid++;
                if (vpos < 0) vpos = k;
                cap = rx_data;
            end
            if (MISO) miso_hi = 1'b1;
            MOSI = 1'($urandom);
        end
    endtask

    task automatic read_back(input logic [7:0] b, output logic [8:0] bits);
        @(negedge clk); tx_valid = 1'b1; tx_data = b;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            bits[8-j] = MISO;
        end
    endtask

    task automatic deselect();
        @(negedge clk); SS_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", MISO); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_checks++; if (rx_data !== 10'h000) begin n_fail++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        n_checks++; if (dut.rd_addr_seen_q !== 1'b0) begin n_fail++; $display("FAIL reset_rd_seen: got %b want 0", dut.rd_addr_seen_q); end
        rst_n = 1'b1;
        rd_model = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_addr();
        int nv, vp; logic [9:0] cap, f; bit mh;
        send_frame(10'h02A, nv, vp, cap, mh);
        n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL wa_count: got %0d want 1", nv); end
        n_checks++; if (vp !== 0) begin n_fail++; $display("FAIL wa_timing: got %0d want 0", vp); end
        n_checks++; if (cap !== 10'h02A) begin n_fail++; $display("FAIL wa_data: got %h want 02a", cap); end
        n_checks++; if (mh !== 1'b0) begin n_fail++; $display("FAIL wa_miso: got %b want 0", mh); end
        deselect();
        for (int r = 0; r < 4; r++) begin
            f = {2'b00, 8'($urandom)};
            send_frame(f, nv, vp, cap, mh);
            n_checks++; if (cap !== f || nv !== 1) begin n_fail++; $display("FAIL wa_rand: got %h/%0d want %h/1", cap, nv, f); end
            deselect();
        end
        repeat (3) @(negedge clk);
        n_checks++; if (rx_data !== f) begin n_fail++; $display("FAIL rx_hold: got %h want %h", rx_data, f); end
    endtask

    task automatic test_write_data();
        int nv, vp; logic [9:0] cap; bit mh; bit seen;
        send_frame(10'h1FF, nv, vp, cap, mh);
        n_checks++; if (nv !== 1 || cap !== 10'h1FF) begin n_fail++; $display("FAIL wd_frame: got %h/%0d want 1ff/1", cap, nv); end
        n_checks++; if (dut.rd_addr_seen_q !== rd_model) begin n_fail++; $display("FAIL wd_rd_seen: got %b want %b", dut.rd_addr_seen_q, rd_model); end
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hFF;
        seen = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk); tx_valid = 1'b0;
            if (MISO) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL stray_tx_valid: got miso %b want 0", seen); end
        deselect();
    endtask

    task automatic test_read_sequence();
        int nv, vp; logic [9:0] cap, fa, fd; bit mh; logic [8:0] bits; logic [7:0] b;
        send_frame(10'h210, nv, vp, cap, mh);
        rd_model = model_rd_next(10'h210, rd_model);
        n_checks++; if (cap !== 10'h210 || nv !== 1) begin n_fail++; $display("FAIL ra_frame: got %h/%0d want 210/1", cap, nv); end
        n_checks++; if (dut.rd_addr_seen_q !== rd_model) begin n_fail++; $display("FAIL ra_rd_seen: got %b want %b", dut.rd_addr_seen_q, rd_model); end
        deselect();
        send_frame(10'h300, nv, vp, cap, mh);
        rd_model = model_rd_next(10'h300, rd_model);
        n_checks++; if (cap !== 10'h300 || nv !== 1 || vp !== 0) begin n_fail++; $display("FAIL rd_frame: got %h/%0d/%0d want 300/1/0", cap, nv, vp); end
        n_checks++; if (mh !== 1'b0) begin n_fail++; $display("FAIL rd_early_miso: got %b want 0", mh); end
        read_back(8'hA5, bits);
        n_checks++; if (bits !== 9'b1010_0101_0) begin n_fail++; $display("FAIL rd_miso_a5: got %b want 101001010", bits); end
        n_checks++; if (dut.rd_addr_seen_q !== rd_model) begin n_fail++; $display("FAIL rd_rd_seen: got %b want %b", dut.rd_addr_seen_q, rd_model); end
        deselect();
        for (int r = 0; r < 3; r++) begin
            fa = {2'b10, 8'($urandom)};
            fd = {2'b11, 8'($urandom)};
            b  = 8'($urandom);
            send_frame(fa, nv, vp, cap, mh);
            rd_model = model_rd_next(fa, rd_model);
            n_checks++; if (cap !== fa) begin n_fail++; $display("FAIL rs_addr: got %h want %h", cap, fa); end
            deselect();
            send_frame(fd, nv, vp, cap, mh);
            rd_model = model_rd_next(fd, rd_model);
            n_checks++; if (cap !== fd) begin n_fail++; $display("FAIL rs_data: got %h want %h", cap, fd); end
            read_back(b, bits);
            n_checks++; if (bits !== {b, 1'b0}) begin n_fail++; $display("FAIL rs_miso: got %b want %b", bits, {b, 1'b0}); end
            deselect();
        end
    endtask

    task automatic test_read_data_first();
        int nv, vp; logic [9:0] cap, f; bit mh; bit seen; logic [8:0] bits; logic [7:0] b;
        f = {2'b11, 8'($urandom)};
        send_frame(f, nv, vp, cap, mh);
        rd_model = model_rd_next(f, rd_model);
        n_checks++; if (dut.state_q !== READ_ADD) begin n_fail++; $display("FAIL rdf_state: got %0d want READ_ADD", dut.state_q); end
        n_checks++; if (cap !== f) begin n_fail++; $display("FAIL rdf_data: got %h want %h", cap, f); end
        n_checks++; if (dut.rd_addr_seen_q !== rd_model) begin n_fail++; $display("FAIL rdf_rd_seen: got %b want %b", dut.rd_addr_seen_q, rd_model); end
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hFF;
        seen = 1'b0;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk); tx_valid = 1'b0;
            if (MISO) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rdf_no_miso: got %b want 0", seen); end
        deselect();
        f = {2'b11, 8'($urandom)}; b = 8'($urandom);
        send_frame(f, nv, vp, cap, mh);
        rd_model = model_rd_next(f, rd_model);
        read_back(b, bits);
        n_checks++; if (bits !== {b, 1'b0}) begin n_fail++; $display("FAIL rdf_followup: got %b want %b", bits, {b, 1'b0}); end
        deselect();
    endtask

    task automatic test_abort();
        int nv, vp; logic [9:0] cap, f; bit mh; int early; logic [8:0] bits; logic [7:0] b;
        f = {2'b10, 8'($urandom)};
        send_frame(f, nv, vp, cap, mh);
        rd_model = model_rd_next(f, rd_model);
        deselect();
        f = {2'b11, 8'($urandom)};
        early = 0;
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rx_valid) early++;
            MOSI = f[9-i];
        end
        @(negedge clk); if (rx_valid) early++; SS_n = 1'b1;
        @(negedge clk); if (rx_valid) early++;
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d want IDLE", dut.state_q); end
        repeat (3) begin @(negedge clk); if (rx_valid) early++; end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL abort_rx_valid: got %0d want 0", early); end
        n_checks++; if (dut.rd_addr_seen_q !== rd_model) begin n_fail++; $display("FAIL abort_rd_seen: got %b want %b", dut.rd_addr_seen_q, rd_model); end
        b = 8'($urandom);
        send_frame(f, nv, vp, cap, mh);
        rd_model = model_rd_next(f, rd_model);
        n_checks++; if (cap !== f || nv !== 1) begin n_fail++; $display("FAIL abort_next: got %h/%0d want %h/1", cap, nv, f); end
        read_back(b, bits);
        n_checks++; if (bits !== {b, 1'b0}) begin n_fail++; $display("FAIL abort_next_miso: got %b want %b", bits, {b, 1'b0}); end
        deselect();
    endtask

    task automatic test_back_to_back();
        int nv, vp; logic [9:0] cap, f; bit mh; logic [8:0] bits; logic [7:0] b; bit rb;
        for (int r = 0; r < 20; r++) begin
            f  = 10'($urandom);
            b  = 8'($urandom);
            rb = model_reads_back(f, rd_model);
            send_frame(f, nv, vp, cap, mh);
            rd_model = model_rd_next(f, rd_model);
            n_checks++; if (cap !== f || nv !== 1 || vp !== 0) begin n_fail++; $display("FAIL b2b_frame%0d: got %h/%0d/%0d want %h/1/0", r, cap, nv, vp, f); end
            if (rb) begin
                read_back(b, bits);
                n_checks++; if (bits !== {b, 1'b0}) begin n_fail++; $display("FAIL b2b_miso%0d: got %b want %b", r, bits, {b, 1'b0}); end
            end
            n_checks++; if (dut.rd_addr_seen_q !== rd_model) begin n_fail++; $display("FAIL b2b_rd_seen%0d: got %b want %b", r, dut.rd_addr_seen_q, rd_model); end
            @(negedge clk); SS_n = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        int nv, vp; logic [9:0] cap, f; bit mh;
        if (!rd_model) begin
            f = {2'b10, 8'($urandom)};
            send_frame(f, nv, vp, cap, mh);
            rd_model = model_rd_next(f, rd_model);
            deselect();
        end
        f = {2'b11, 8'($urandom)};
        send_frame(f, nv, vp, cap, mh);
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk); tx_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (MISO !== 1'b1) begin n_fail++; $display("FAIL rst_pre_miso: got %b want 1", MISO); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL rst_async_miso: got %b want 0", MISO); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_rx_valid: got %b want 0", rx_valid); end
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL rst_async_state: got %0d want IDLE", dut.state_q); end
        n_checks++; if (dut.rd_addr_seen_q !== 1'b0) begin n_fail++; $display("FAIL rst_async_rd_seen: got %b want 0", dut.rd_addr_seen_q); end
        rd_model = 1'b0;
        @(negedge clk); SS_n = 1'b1; rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read_sequence();
        test_read_data_first();
        test_abort();
        test_back_to_back();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
